// File: rtl/coef_bank_loader_pkg.sv
// coef_pkg: types and defaults shared by the coefficient bank loader files.
//   coef_ld_state_t : loader FSM state encoding
//   *_DEF           : default parameter values used by the loader modules
// The coefficient type depends on the COEFW parameter, so each module
// declares its own coef_t from these defaults.
package coef_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PEND} coef_ld_state_t;

    localparam int COEFW_DEF = 18;
    localparam int TM_DEF    = 2;
    localparam int CW_DEF    = 1;

endpackage

// File: rtl/coef_shadow_bank.sv
// coef_shadow_bank: the shadow and active coefficient register arrays.
//   clk, rst  : clock and synchronous active-high reset (both arrays clear)
//   wr_en     : write wr_data into shadow[wr_idx]
//   wr_idx    : shadow write index
//   wr_data   : coefficient to store
//   copy_en   : copy the whole shadow array into the active array in one cycle
//   active    : active array (registered)
module coef_shadow_bank
    import coef_pkg::*;
#(
    parameter int COEFW = COEFW_DEF,
    parameter int TM    = TM_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CW-1:0]           wr_idx,
    input  logic signed [COEFW-1:0] wr_data,
    input  logic                    copy_en,
    output logic signed [COEFW-1:0] active [TM]
);

    typedef logic signed [COEFW-1:0] coef_t;

    coef_t shadow [TM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TM; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TM; i++) begin
                if (wr_en && (wr_idx == CW'(i)))
                    shadow[i] <= wr_data;
                // The loader never writes and copies in the same cycle
                // (no transfers in PEND), so active sees a complete set.
                if (copy_en)
                    active[i] <= shadow[i];
            end
        end
    end

endmodule

// File: rtl/coef_bank_loader.sv
// coef_bank_loader: fills a shadow coefficient bank from a valid/ready stream
// and swaps it into the active bank at a safe point.
//   clk, rst   : clock, synchronous active-high reset
//   s_valid    : stream word valid
//   s_ready    : loader can accept a word (registered)
//   s_data     : coefficient, index 0 first
//   s_last     : final word of a set
//   swap_en    : safe point for the bank swap
//   coef_pack  : active bank [TM], registered
//   busy       : high in LOAD, DRAIN and PEND
//   load_done  : one-cycle pulse in the cycle after the swap
//   load_err   : one-cycle pulse after a set of the wrong length is rejected
module coef_bank_loader
    import coef_pkg::*;
#(
    parameter int COEFW = COEFW_DEF,
    parameter int TM    = TM_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [COEFW-1:0] s_data,
    input  logic                    s_last,
    input  logic                    swap_en,
    output logic signed [COEFW-1:0] coef_pack [TM],
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam logic [CW-1:0] LAST_IDX = CW'(TM - 1);

    coef_ld_state_t state, state_nx;
    logic [CW-1:0]  wr_idx, wr_idx_nx;
    logic           xfer;
    logic           wr_en;
    logic           copy_en;
    logic           err_nx;
    logic           done_nx;

    assign xfer = s_valid && s_ready;
    assign busy = (state != IDLE);

    always_comb begin
        state_nx  = state;
        wr_idx_nx = wr_idx;
        wr_en     = 1'b0;
        copy_en   = 1'b0;
        err_nx    = 1'b0;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                // wr_idx is always 0 here, so the first word lands in shadow[0].
                if (xfer) begin
                    if (s_last) begin
                        err_nx = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        wr_idx_nx = CW'(1);
                        state_nx  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        if (wr_idx == LAST_IDX) begin
                            state_nx = PEND;
                        end else begin
                            err_nx    = 1'b1;
                            wr_idx_nx = '0;
                            state_nx  = IDLE;
                        end
                    end else if (wr_idx == LAST_IDX) begin
                        // Bank is full but the set continues: hold the index
                        // and discard the rest of the set.
                        state_nx = DRAIN;
                    end else begin
                        wr_idx_nx = wr_idx + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (xfer && s_last) begin
                    err_nx    = 1'b1;
                    wr_idx_nx = '0;
                    state_nx  = IDLE;
                end
            end
            PEND: begin
                if (swap_en) begin
                    copy_en   = 1'b1;
                    done_nx   = 1'b1;
                    wr_idx_nx = '0;
                    state_nx  = IDLE;
                end
            end
            default: begin
                wr_idx_nx = '0;
                state_nx  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_idx    <= '0;
            s_ready   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_idx    <= wr_idx_nx;
            // Registered from the next state so it drops on the same edge
            // that enters PEND and stalls the stream until the swap.
            s_ready   <= (state_nx != PEND);
            load_done <= done_nx;
            load_err  <= err_nx;
        end
    end

    coef_shadow_bank #(
        .COEFW (COEFW),
        .TM    (TM),
        .CW    (CW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (s_data),
        .copy_en (copy_en),
        .active  (coef_pack)
    );

endmodule

// File: tb/tb_coef_bank_loader.sv
// Testbench for coef_bank_loader: a TM=4 instance driven from a table of
// directed vectors and a TM=2 instance driven with randomly gapped sets.
module tb_coef_bank_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // TM=4 instance
    logic               v4, rdy4, l4, sw4, busy4, done4, err4;
    logic signed [17:0] d4;
    logic signed [17:0] pack4 [4];

    // TM=2 instance
    logic               v2, rdy2, l2, sw2, busy2, done2, err2;
    logic signed [17:0] d2;
    logic signed [17:0] pack2 [2];

    coef_bank_loader #(.COEFW(18), .TM(4), .CW(2)) dut4 (
        .clk(clk), .rst(rst), .s_valid(v4), .s_ready(rdy4), .s_data(d4),
        .s_last(l4), .swap_en(sw4), .coef_pack(pack4), .busy(busy4),
        .load_done(done4), .load_err(err4)
    );

    coef_bank_loader #(.COEFW(18), .TM(2), .CW(1)) dut2 (
        .clk(clk), .rst(rst), .s_valid(v2), .s_ready(rdy2), .s_data(d2),
        .s_last(l2), .swap_en(sw2), .coef_pack(pack2), .busy(busy2),
        .load_done(done2), .load_err(err2)
    );

    // Inputs applied before an edge and outputs expected just after it.
    typedef struct {
        bit rst, v, l, sw;
        int d;
        bit rdy, busy, done, err;
        int p [4];
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit v, input int d, input bit l, input bit sw,
                       input bit rdy, input bit busy, input bit done, input bit err,
                       input int p0, input int p1, input int p2, input int p3);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.l = l; t.sw = sw;
        t.rdy = rdy; t.busy = busy; t.done = done; t.err = err;
        t.p[0] = p0; t.p[1] = p1; t.p[2] = p2; t.p[3] = p3;
        vecs.push_back(t);
    endtask

    logic signed [17:0] exp2 [2];

    initial begin
        rst = 1'b1;
        v4 = 0; d4 = '0; l4 = 0; sw4 = 0;
        v2 = 0; d2 = '0; l2 = 0; sw2 = 0;

        // 1: reset state, full set, swap three cycles into PEND
        add(1,0,0,0,0, 0,0,0,0, 0,0,0,0);
        add(1,0,0,0,0, 0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 1,0,0,0, 0,0,0,0);
        add(0,1,1,0,0, 1,1,0,0, 0,0,0,0);
        add(0,1,2,0,0, 1,1,0,0, 0,0,0,0);
        add(0,1,3,0,0, 1,1,0,0, 0,0,0,0);
        add(0,1,4,1,0, 0,1,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,1,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,1,0,0, 0,0,0,0);
        add(0,0,0,0,1, 1,0,1,0, 1,2,3,4);
        add(0,0,0,0,0, 1,0,0,0, 1,2,3,4);
        // 2: short set rejected, then a full set
        add(0,1,5,0,0, 1,1,0,0, 1,2,3,4);
        add(0,1,6,0,0, 1,1,0,0, 1,2,3,4);
        add(0,1,7,1,0, 1,0,0,1, 1,2,3,4);
        add(0,0,0,0,0, 1,0,0,0, 1,2,3,4);
        add(0,1,9,0,0, 1,1,0,0, 1,2,3,4);
        add(0,1,9,0,0, 1,1,0,0, 1,2,3,4);
        add(0,1,9,0,0, 1,1,0,0, 1,2,3,4);
        add(0,1,9,1,0, 0,1,0,0, 1,2,3,4);
        add(0,0,0,0,1, 1,0,1,0, 9,9,9,9);
        add(0,0,0,0,0, 1,0,0,0, 9,9,9,9);
        // 3: long set drained, swap_en ignored
        add(0,1,11,0,1, 1,1,0,0, 9,9,9,9);
        add(0,1,12,0,1, 1,1,0,0, 9,9,9,9);
        add(0,1,13,0,1, 1,1,0,0, 9,9,9,9);
        add(0,1,14,0,1, 1,1,0,0, 9,9,9,9);
        add(0,1,15,0,1, 1,1,0,0, 9,9,9,9);
        add(0,1,16,1,1, 1,0,0,1, 9,9,9,9);
        add(0,0,0,0,1,  1,0,0,0, 9,9,9,9);
        // 4: swap_en held through the load
        add(0,1,21,0,1,  1,1,0,0, 9,9,9,9);
        add(0,1,-22,0,1, 1,1,0,0, 9,9,9,9);
        add(0,1,23,0,1,  1,1,0,0, 9,9,9,9);
        add(0,1,-24,1,1, 0,1,0,0, 9,9,9,9);
        add(0,0,0,0,1,   1,0,1,0, 21,-22,23,-24);
        add(0,0,0,0,1,   1,0,0,0, 21,-22,23,-24);
        add(0,0,0,0,0,   1,0,0,0, 21,-22,23,-24);
        // 5: reset mid-load, word offered while s_ready is still low, extreme values
        add(0,1,31,0,0, 1,1,0,0, 21,-22,23,-24);
        add(0,1,32,0,0, 1,1,0,0, 21,-22,23,-24);
        add(1,1,33,0,0, 0,0,0,0, 0,0,0,0);
        add(0,1,99,0,0, 1,0,0,0, 0,0,0,0);
        add(0,1,131071,0,0,  1,1,0,0, 0,0,0,0);
        add(0,1,-131072,0,0, 1,1,0,0, 0,0,0,0);
        add(0,1,1,0,0,       1,1,0,0, 0,0,0,0);
        add(0,1,-1,1,0,      0,1,0,0, 0,0,0,0);
        add(0,0,0,0,1,       1,0,1,0, 131071,-131072,1,-1);
        add(0,0,0,0,0,       1,0,0,0, 131071,-131072,1,-1);

        @(posedge clk); #1;
        foreach (vecs[k]) begin
            rst = vecs[k].rst;
            v4  = vecs[k].v;
            d4  = 18'(vecs[k].d);
            l4  = vecs[k].l;
            sw4 = vecs[k].sw;
            @(posedge clk); #1;
            chk($sformatf("v%0d s_ready", k), int'(rdy4), int'(vecs[k].rdy));
            chk($sformatf("v%0d busy", k), int'(busy4), int'(vecs[k].busy));
            chk($sformatf("v%0d load_done", k), int'(done4), int'(vecs[k].done));
            chk($sformatf("v%0d load_err", k), int'(err4), int'(vecs[k].err));
            for (int i = 0; i < 4; i++)
                chk($sformatf("v%0d coef_pack[%0d]", k, i), int'(pack4[i]), vecs[k].p[i]);
        end
        v4 = 0; sw4 = 0; l4 = 0;

        // 6: TM=2 with random valid gaps; scoreboard against each accepted set
        for (int s = 0; s < 25; s++) begin
            for (int w = 0; w < 2; w++) begin
                bit acc;
                int tries;
                acc = 0;
                tries = 0;
                exp2[w] = 18'($urandom_range(0, 262143));
                while (!acc && tries < 60) begin
                    v2 = 1'($urandom_range(0, 1));
                    d2 = exp2[w];
                    l2 = (w == 1);
                    acc = v2 && rdy2;
                    @(posedge clk); #1;
                    tries++;
                end
                v2 = 0; l2 = 0;
                if (!acc) chk($sformatf("set%0d word%0d accept timeout", s, w), 0, 1);
            end
            chk($sformatf("set%0d s_ready in PEND", s), int'(rdy2), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            sw2 = 1;
            begin
                int waitc;
                waitc = 0;
                while (!done2 && waitc < 5) begin
                    @(posedge clk); #1;
                    waitc++;
                end
                sw2 = 0;
                chk($sformatf("set%0d load_done", s), int'(done2), 1);
                chk($sformatf("set%0d load_err", s), int'(err2), 0);
                chk($sformatf("set%0d coef_pack[0]", s), int'(pack2[0]), int'(exp2[0]));
                chk($sformatf("set%0d coef_pack[1]", s), int'(pack2[1]), int'(exp2[1]));
            end
            @(posedge clk); #1;
            chk($sformatf("set%0d load_done pulse width", s), int'(done2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
